adder_tree_sequencer: RTL and testbench
=======================================

// Module: adder_tree_sequencer
// PURPOSE
//  Flow controller wrapped around the 4-stage pipelined adder tree, which has no enable.
//  Accepts product vectors over valid/ready and drives them to the tree.
//  Tracks in-flight windows with a latency-matched tag pipe.
//  Captures the tree's sums into a result FIFO so downstream backpressure never drops data.
//  Sequences one frame of frame_windows convolution windows per start pulse and tags the last result.
// PARAMETERS
//  PROD_BUS_W   16*3*3*3*3  total product bus width (PRODUCT_WIDTH*WIDTH*HEIGHT*DEPTH*NUM_FILTER)
//  SUM_BUS_W    32*3*3      total sum bus width (SUM_WIDTH*DEPTH*NUM_FILTER)
//  TREE_LAT     4           adder tree latency in clocks, from products applied to sums valid
//  FIFO_DEPTH   8           result FIFO entries; power of two, >= TREE_LAT
//  CNT_W        16          width of the window counter and of frame_windows
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           synchronous reset, active-low (0 = reset)
//  start          in   1           one-cycle pulse; starts a frame while in IDLE
//  frame_windows  in   CNT_W       windows in this frame; sampled on an accepted start
//  busy           out  1           high in every state except IDLE
//  done           out  1           one-cycle pulse in the DONE state
//  in_valid       in   1           product vector valid
//  in_ready       out  1           controller can accept a product vector
//  in_products    in   PROD_BUS_W  product vector from the multiplier array
//  tree_products  out  PROD_BUS_W  to the adder tree 'products' input; equals in_products (combinational)
//  tree_sums      in   SUM_BUS_W   from the adder tree 'sums_out' output
//  out_valid      out  1           result valid (FIFO not empty)
//  out_ready      in   1           downstream accepts the result
//  out_sums       out  SUM_BUS_W   head entry of the FIFO
//  out_last       out  1           head entry is the last window of the frame
// BEHAVIOUR
//  Reset (rst=0 on an edge): state=IDLE; tag pipe, FIFO pointers, count and window counter cleared.
//   While held: busy=0, done=0, in_ready=0, out_valid=0, out_last=0.
//   Reset mid-frame abandons all in-flight and buffered results. The tree itself is not reset.
//  FSM IDLE->RUN: start=1 and frame_windows!=0; load remaining=frame_windows.
//   IDLE->DONE: start=1 and frame_windows==0. start outside IDLE is ignored.
//  RUN: accept = in_valid & in_ready; in_ready = (fifo_count + inflight) < FIFO_DEPTH.
//   inflight = number of set valid bits in the tag pipe. This credit rule guarantees FIFO space.
//   On accept: remaining decrements. The tag pipe stage 0 loads {valid=1, last=(remaining==1)}.
//   The accept with remaining==1 moves the FSM RUN->DRAIN.
//  DRAIN: in_ready=0. DRAIN->DONE when the tag pipe and the FIFO are both empty.
//  DONE: done=1 for exactly one cycle, then IDLE.
//  Tag pipe: TREE_LAT-deep shift register of {valid,last}, advances every cycle regardless of out_ready.
//   When the tail has valid=1, write {tree_sums, last} into the FIFO on that same edge.
//   The tail aligns to the edge on which sums_out first shows the result, TREE_LAT edges after accept.
//  FIFO: first-word fall-through. Pop when out_valid & out_ready.
//   A simultaneous push and pop keeps count unchanged, including when full (count==FIFO_DEPTH).
//   Push is never attempted when full; this is asserted in simulation.
//  A throughput of 1 window per clock is sustained when out_ready=1 continuously.
//  out_sums and out_last are held stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//  ADDER_SEQ_PERF_EN defined: add outputs stall_cycles[31:0] and bp_cycles[31:0].
//   Both clear on reset and on an accepted start, and saturate at 2^32-1.
//   stall_cycles counts RUN cycles with in_valid=1 and in_ready=0.
//   bp_cycles counts cycles with out_valid=1 and out_ready=0.
//  ADDER_SEQ_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package cnn_pkg: PRODUCT_WIDTH, SUM_WIDTH, kernel dimensions, ADDER_TREE_LAT=4,
//   and the FSM state enum {IDLE,RUN,DRAIN,DONE}.
//  One sub-module: sync_result_fifo, parameterised by width and depth.
//   Outputs count, full and empty; first-word fall-through.
//  The tag pipe, credit logic and FSM live in the top level.
// TESTING
//  The bench models the tree as a TREE_LAT-cycle delay of sum(products) per (depth, filter) group.
//  1 Basic frame: frame_windows=5, in_valid=1, out_ready=1 throughout.
//    -> 5 results, the first on the 5th edge after the first accept.
//    -> out_last only on the 5th result; done pulses 1 cycle after the last pop; busy then falls.
//  2 Backpressure: frame_windows=20, out_ready=0 throughout.
//    -> exactly 8 accepts, then in_ready=0; no results lost.
//    -> after releasing out_ready: 20 in-order results, sums matching the model.
//  3 Random in_valid and out_ready at 50% each, frame_windows=100.
//    -> results match the model in order; FIFO overflow assertion never fires.
//  4 Zero frame: start with frame_windows=0 -> done on the next cycle; in_ready stays 0; no outputs.
//  5 Reset mid-frame: rst=0 for 1 cycle after 3 accepts with 2 in flight.
//    -> out_valid=0 and busy=0 next cycle; a following 4-window frame yields only 4 results.
//  6 start pulsed during RUN -> ignored; remaining is unchanged.
//    ADDER_SEQ_PERF_EN: scenario 2 gives bp_cycles equal to the cycle count where out_ready=0 and out_valid=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the frame sequencer state encoding.
package cnn_pkg;

    localparam int unsigned PRODUCT_WIDTH  = 16;
    localparam int unsigned SUM_WIDTH      = 32;
    localparam int unsigned KERNEL_WIDTH   = 3;
    localparam int unsigned KERNEL_HEIGHT  = 3;
    localparam int unsigned KERNEL_DEPTH   = 3;
    localparam int unsigned NUM_FILTER     = 3;
    localparam int unsigned ADDER_TREE_LAT = 4;

    // Products feeding one (depth, filter) sum.
    localparam int unsigned TAPS_PER_SUM = KERNEL_WIDTH * KERNEL_HEIGHT;
    localparam int unsigned NUM_SUMS     = KERNEL_DEPTH * NUM_FILTER;

    localparam int unsigned PROD_BUS_W_DEF = PRODUCT_WIDTH * TAPS_PER_SUM * NUM_SUMS;
    localparam int unsigned SUM_BUS_W_DEF  = SUM_WIDTH * NUM_SUMS;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

endpackage

// File: rtl/adder_tree_sequencer_if.sv
// Product/result streams plus the adder tree connection of the sequencer.
// slave: the sequencer side; master: upstream/downstream/tree side.
interface adder_tree_sequencer_if
    import cnn_pkg::*;
#(
    parameter int unsigned PROD_BUS_W = PROD_BUS_W_DEF,
    parameter int unsigned SUM_BUS_W  = SUM_BUS_W_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PROD_BUS_W-1:0] in_products;
    logic [PROD_BUS_W-1:0] tree_products;
    logic [SUM_BUS_W-1:0]  tree_sums;
    logic                  out_valid;
    logic                  out_ready;
    logic [SUM_BUS_W-1:0]  out_sums;
    logic                  out_last;

    modport slave (
        input  in_valid, in_products, tree_sums, out_ready,
        output in_ready, tree_products, out_valid, out_sums, out_last
    );

    modport master (
        output in_valid, in_products, tree_sums, out_ready,
        input  in_ready, tree_products, out_valid, out_sums, out_last
    );
endinterface

// File: rtl/sync_result_fifo.sv
// First-word fall-through result FIFO with synchronous active-low reset.
// Simultaneous push and pop leaves the count unchanged, also when full.
module sync_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/adder_tree_sequencer.sv
// Flow controller around the enable-less pipelined adder tree: credit-based input
// acceptance, latency-matched tag pipe, result FIFO and per-frame sequencing.
// Optional build macro ADDER_SEQ_PERF_EN adds stall_cycles/bp_cycles counters.
module adder_tree_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned PROD_BUS_W = PROD_BUS_W_DEF,
    parameter int unsigned SUM_BUS_W  = SUM_BUS_W_DEF,
    parameter int unsigned TREE_LAT   = ADDER_TREE_LAT,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      frame_windows,
    output logic                  busy,
    output logic                  done,
    adder_tree_sequencer_if.slave bus
`ifdef ADDER_SEQ_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bp_cycles
`endif
);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRW  = CNTW + 1;

    seq_state_t         state_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [TREE_LAT-1:0] tag_valid_q;
    logic [TREE_LAT-1:0] tag_last_q;
    logic [CRW-1:0]     inflight;
    logic               in_ready;
    logic               accept;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNTW-1:0]    fifo_count;
    logic [SUM_BUS_W:0] fifo_rdata;

    // Count windows still inside the tree.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < TREE_LAT; i++) begin
            inflight = inflight + CRW'(tag_valid_q[i]);
        end
    end

    // Credit: every in-flight window already owns a FIFO slot, so a push can never overflow.
    assign in_ready = (state_q == RUN) &&
                      (({1'b0, fifo_count} + inflight) < CRW'(FIFO_DEPTH));
    assign accept   = bus.in_valid & in_ready;

    // Frame sequencing: IDLE -> RUN/DONE on start, RUN -> DRAIN on last accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (frame_windows != '0) begin
                            state_q     <= RUN;
                            remaining_q <= frame_windows;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((tag_valid_q == '0) && fifo_empty) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipe shifts every cycle, in lockstep with the tree which has no stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_valid_q <= '0;
            tag_last_q  <= '0;
        end else begin
            tag_valid_q <= {tag_valid_q[TREE_LAT-2:0], accept};
            tag_last_q  <= {tag_last_q[TREE_LAT-2:0], accept && (remaining_q == CNT_W'(1))};
        end
    end

    assign fifo_push = tag_valid_q[TREE_LAT-1];
    assign fifo_pop  = ~fifo_empty & bus.out_ready;

    sync_result_fifo #(
        .WIDTH (SUM_BUS_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({tag_last_q[TREE_LAT-1], bus.tree_sums}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.in_ready      = in_ready;
    assign bus.tree_products = bus.in_products;
    assign bus.out_valid     = ~fifo_empty;
    assign bus.out_sums      = fifo_rdata[SUM_BUS_W-1:0];
    assign bus.out_last      = fifo_rdata[SUM_BUS_W] & ~fifo_empty;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);

`ifdef ADDER_SEQ_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] bp_q;

    // Saturating stall/backpressure counters, cleared by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (!rst || ((state_q == IDLE) && start)) begin
            stall_q <= '0;
            bp_q    <= '0;
        end else begin
            if ((state_q == RUN) && bus.in_valid && !in_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (!fifo_empty && !bus.out_ready && (bp_q != '1)) begin
                bp_q <= bp_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign bp_cycles    = bp_q;
`endif

`ifndef SYNTHESIS
    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && fifo_full));
`endif
endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Self-checking bench for adder_tree_sequencer with a delay-line adder tree model
// and a scoreboard of expected sums filled on each accepted product vector.
module tb_adder_tree_sequencer;
    import cnn_pkg::*;

    localparam int unsigned PROD_BUS_W = PROD_BUS_W_DEF;
    localparam int unsigned SUM_BUS_W  = SUM_BUS_W_DEF;
    localparam int unsigned TREE_LAT   = ADDER_TREE_LAT;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef logic [SUM_BUS_W:0] val_t;
    typedef struct packed {
        logic                 last;
        logic [SUM_BUS_W-1:0] sums;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] frame_windows;
    logic        busy;
    logic        done;
`ifdef ADDER_SEQ_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] bp_cycles;
`endif

    adder_tree_sequencer_if #(.PROD_BUS_W(PROD_BUS_W), .SUM_BUS_W(SUM_BUS_W)) bus ();

    adder_tree_sequencer #(
        .PROD_BUS_W (PROD_BUS_W),
        .SUM_BUS_W  (SUM_BUS_W),
        .TREE_LAT   (TREE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .frame_windows (frame_windows),
        .busy          (busy),
        .done          (done),
        .bus           (bus)
`ifdef ADDER_SEQ_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .bp_cycles     (bp_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SUM_BUS_W-1:0] model_sum(input logic [PROD_BUS_W-1:0] p);
        logic [SUM_BUS_W-1:0] r;
        logic [31:0]          s;
        r = '0;
        for (int g = 0; g < NUM_SUMS; g++) begin
            s = '0;
            for (int k = 0; k < TAPS_PER_SUM; k++) begin
                s = s + 32'(p[(g * TAPS_PER_SUM + k) * PRODUCT_WIDTH +: PRODUCT_WIDTH]);
            end
            r[g * SUM_WIDTH +: SUM_WIDTH] = s;
        end
        return r;
    endfunction

    // Adder tree model: combinational sum followed by TREE_LAT registers, no enable.
    logic [SUM_BUS_W-1:0] tree_q [TREE_LAT];
    always_ff @(posedge clk) begin
        tree_q[0] <= model_sum(bus.tree_products);
        for (int i = 1; i < TREE_LAT; i++) tree_q[i] <= tree_q[i-1];
    end
    assign bus.tree_sums = tree_q[TREE_LAT-1];

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    exp_t sb [$];
    int   exp_frame_len, acc_count, res_count, bp_model;
    int   first_acc_edge, first_out_edge, last_pop_edge, done_edge;
    bit   seen_out, held_v;
    val_t held;

    task automatic check_eq(input string tag, input val_t got, input val_t exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output/accept observation, done mid-cycle where all signals are settled.
    task automatic monitor();
        exp_t e;
        if (!rst) begin
            sb.delete();
            held_v = 1'b0;
            return;
        end
        if (bus.out_valid) begin
            if (held_v) check_eq("hold", {bus.out_last, bus.out_sums}, held);
            if (!seen_out) begin
                seen_out       = 1'b1;
                first_out_edge = cyc;
            end
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", val_t'(1), val_t'(0));
                end else begin
                    e = sb.pop_front();
                    check_eq("sums", val_t'(bus.out_sums), val_t'(e.sums));
                    check_eq("last", val_t'(bus.out_last), val_t'(e.last));
                end
                res_count++;
                if (bus.out_last) last_pop_edge = cyc + 1;
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held   = {bus.out_last, bus.out_sums};
                bp_model++;
            end
        end else begin
            held_v = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
            acc_count++;
            if (acc_count == 1) first_acc_edge = cyc + 1;
            e.sums = model_sum(bus.in_products);
            e.last = (acc_count == exp_frame_len);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rand_products();
        for (int k = 0; k < TAPS_PER_SUM * NUM_SUMS; k++) begin
            bus.in_products[k * PRODUCT_WIDTH +: PRODUCT_WIDTH] = 16'($urandom);
        end
    endtask

    task automatic start_frame(input int n);
        exp_frame_len = n;
        acc_count     = 0;
        res_count     = 0;
        bp_model      = 0;
        seen_out      = 1'b0;
        start         = 1'b1;
        frame_windows = 16'(n);
        tick();
        start         = 1'b0;
    endtask

    task automatic drive_until_done(input int vpct, input int rpct, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus.in_valid  = ($urandom_range(99) < vpct);
            bus.out_ready = ($urandom_range(99) < rpct);
            rand_products();
            tick();
            if (done) begin
                got       = 1'b1;
                done_edge = cyc;
                break;
            end
        end
        check_eq("done_seen", val_t'(got), val_t'(1));
    endtask

    task automatic frame_end(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check_eq("done_pulse", val_t'(done), val_t'(0));
        check_eq("busy_fall", val_t'(busy), val_t'(0));
        check_eq("results", val_t'(res_count), val_t'(n));
        check_eq("sb_empty", val_t'(sb.size()), val_t'(0));
    endtask

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        frame_windows = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_products = '0;
        exp_frame_len = 0;
        acc_count     = 0;
        res_count     = 0;
        bp_model      = 0;
        seen_out      = 1'b0;
        held_v        = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", val_t'(busy), val_t'(0));
        check_eq("rst_done", val_t'(done), val_t'(0));
        check_eq("rst_in_ready", val_t'(bus.in_ready), val_t'(0));
        check_eq("rst_out_valid", val_t'(bus.out_valid), val_t'(0));
        check_eq("rst_out_last", val_t'(bus.out_last), val_t'(0));
        rst = 1'b1;
        tick();

        // 1: basic frame with full throughput
        start_frame(5);
        drive_until_done(100, 100, 100);
        check_eq("latency", val_t'(first_out_edge - first_acc_edge), val_t'(TREE_LAT));
        check_eq("done_after_pop", val_t'(done_edge - last_pop_edge), val_t'(1));
        frame_end(5);

        // 2: full backpressure fills exactly the FIFO credit
        start_frame(20);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_products();
            tick();
        end
        check_eq("bp_accepts", val_t'(acc_count), val_t'(FIFO_DEPTH));
        check_eq("bp_in_ready", val_t'(bus.in_ready), val_t'(0));
        check_eq("bp_out_valid", val_t'(bus.out_valid), val_t'(1));
        drive_until_done(100, 100, 200);
`ifdef ADDER_SEQ_PERF_EN
        check_eq("bp_cycles", val_t'(bp_cycles), val_t'(bp_model));
`endif
        frame_end(20);

        // 3: random valid/ready
        start_frame(100);
        drive_until_done(50, 50, 2000);
        frame_end(100);

        // 4: zero-length frame
        start_frame(0);
        bus.in_valid = 1'b1;
        check_eq("zero_done", val_t'(done), val_t'(1));
        check_eq("zero_in_ready", val_t'(bus.in_ready), val_t'(0));
        tick();
        check_eq("zero_done_fall", val_t'(done), val_t'(0));
        check_eq("zero_busy", val_t'(busy), val_t'(0));
        check_eq("zero_out_valid", val_t'(bus.out_valid), val_t'(0));
        check_eq("zero_accepts", val_t'(acc_count), val_t'(0));
        bus.in_valid = 1'b0;

        // 5: reset in the middle of a frame
        start_frame(10);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 0 || i >= 3);
            rand_products();
            tick();
        end
        check_eq("pre_rst_accepts", val_t'(acc_count), val_t'(3));
        check_eq("pre_rst_valid", val_t'(bus.out_valid), val_t'(1));
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("post_rst_valid", val_t'(bus.out_valid), val_t'(0));
        check_eq("post_rst_busy", val_t'(busy), val_t'(0));
        tick();
        start_frame(4);
        drive_until_done(100, 100, 200);
        frame_end(4);

        // 6: start during RUN is ignored
        start_frame(6);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.in_valid  = 1'b0;
        start         = 1'b1;
        frame_windows = 16'd50;
        tick();
        start         = 1'b0;
        check_eq("restart_busy", val_t'(busy), val_t'(1));
        drive_until_done(100, 100, 200);
        frame_end(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
